laser_rx_deframer: RTL and testbench

Receive-side bit deframer for the laser link. It oversamples the raw photodiode comparator line and recovers asynchronous serial frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), with idle high. Each good byte is pushed into the downstream receive FIFO through its `in`/`din`/`full` interface. Framing and overrun faults are reported as sticky flags.

---
 rtl/laser_rx_deframer.sv | 135 +++++++++++++
 tb/tb_laser_rx_deframer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/laser_rx_deframer.sv
// rtl/laser_rx_deframer.sv - oversampling 8N1 deframer for the laser link receive path
module laser_rx_deframer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_in,
    input  logic       fifo_full,
    input  logic       clr_err,
    output logic       push,
    output logic [7:0] dout,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic          sync1, rx_s, hist1, hist2;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          vote;
    logic          do_push, set_fe, set_ov;

    // Majority of the last three synchronised samples rejects single-cycle spikes.
    assign vote = (rx_s & hist1) | (rx_s & hist2) | (hist1 & hist2);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        do_push   = 1'b0;
        set_fe    = 1'b0;
        set_ov    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = 4'd0;
                    state_n   = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    shreg_n   = {vote, shreg[7:1]};
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == 4'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (vote) begin
                        // A full FIFO drops the byte here so push never meets a full FIFO.
                        if (fifo_full) begin
                            set_ov = 1'b1;
                        end else begin
                            do_push = 1'b1;
                        end
                        state_n = S_IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            hist1     <= 1'b1;
            hist2     <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 4'd0;
            shreg     <= 8'h00;
            push      <= 1'b0;
            dout      <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= rx_in;
            rx_s      <= sync1;
            hist1     <= rx_s;
            hist2     <= hist1;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            push      <= do_push;
            if (do_push) begin
                dout <= shreg;
            end
            frame_err <= set_fe | (frame_err & ~clr_err);
            overrun   <= set_ov | (overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_laser_rx_deframer.sv
// tb/tb_laser_rx_deframer.sv - scoreboard bench for laser_rx_deframer
module tb_laser_rx_deframer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_in;
    logic       fifo_full;
    logic       clr_err;
    logic       push;
    logic [7:0] dout;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    laser_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_in     (rx_in),
        .fifo_full (fifo_full),
        .clr_err   (clr_err),
        .push      (push),
        .dout      (dout),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] last_dout = 8'h00;
    logic fe_m = 1'b0;
    logic ov_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every push must match the oldest expected byte at its predicted cycle.
    always @(negedge clk) begin
        if (rstn && push) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_push: got dout %0h expected no push (cycle %0d)", dout, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("push_data", {24'h0, dout}, {24'h0, e.b});
                check("push_time", cyc, e.t);
            end
        end
    end

    task automatic idle(input int n);
        rx_in     = 1'b1;
        fifo_full = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame (start, 8 data LSB first, stop) and updates the reference model.
    // A push appears one cycle after the stop-bit centre, 155 TB cycles after the start drive.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic spikes,
                              input logic full, input int nbits);
        logic [9:0] bits;
        int s;
        bits = {stop, b, 1'b0};
        s = cyc;
        if (nbits == 10) begin
            if (!stop) begin
                fe_m = 1'b1;
            end else if (full) begin
                ov_m = 1'b1;
            end else begin
                q.push_back('{b: b, t: s + 155});
                last_dout = b;
            end
        end
        for (int i = 0; i < nbits * CPB; i++) begin
            logic v;
            v = bits[i / CPB];
            if (spikes && (i % CPB) == CPB / 2) v = ~v;
            rx_in     = v;
            fifo_full = full;
            @(negedge clk);
        end
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        fe_m = 1'b0;
        ov_m = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, fe_m});
        check({tag, "_overrun"}, {31'h0, overrun}, {31'h0, ov_m});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rstn = 1'b0; rx_in = 1'b1; fifo_full = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_push", {31'h0, push}, 32'h0);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check_flags("rst");
        rstn = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 10);
        idle(10);
        check_flags("a5");

        // 4-cycle low glitch: busy only from T+1 to T+8.
        s = cyc;
        for (int i = 0; i < 16; i++) begin
            rx_in = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("glitch_busy", {31'h0, busy}, {31'h0, (i >= 2 && i <= 9)});
        end
        check_flags("glitch");
        idle(5);

        // Bad stop bit, line held low: BREAK holds until the line returns high.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 10);
        for (int i = 0; i < 40; i++) begin
            rx_in = 1'b0;
            @(negedge clk);
        end
        check("break_busy", {31'h0, busy}, 32'h1);
        check_flags("break");
        idle(4);
        check("break_exit_busy", {31'h0, busy}, 32'h0);
        clear_flags();
        check_flags("clr");

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 10);
        idle(5);
        check_flags("ovr");
        check("ovr_dout", {24'h0, dout}, {24'h0, last_dout});

        // Reset in the middle of data bit 4, then a clean frame.
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 5);
        for (int i = 0; i < CPB / 2; i++) begin
            rx_in = 1'b0;
            @(negedge clk);
        end
        rstn = 1'b0; rx_in = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        last_dout = 8'h00; fe_m = 1'b0; ov_m = 1'b0;
        check("mrst_push", {31'h0, push}, 32'h0);
        check("mrst_dout", {24'h0, dout}, 32'h0);
        check("mrst_busy", {31'h0, busy}, 32'h0);
        check_flags("mrst");
        idle(30);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 10);
        idle(3);

        // Back-to-back with centre spikes: pushes exactly 160 cycles apart.
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 10);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 10);
        idle(3);
        check_flags("b2b");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic stop, full, spk;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            full = ($urandom_range(0, 4) == 0);
            spk  = 1'($urandom);
            send_frame(b, stop, spk, full, 10);
            check_flags("rnd");
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                clear_flags();
                check_flags("rnd_clr");
            end
            idle(stop ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end

        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
